// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types and defaults for the 2x2 systolic array controller
package systolic_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int MAX_ROWS_DEF = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W1,
        S_LOAD_W0,
        S_SWITCH,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

endpackage

// File: rtl/systolic_deskew.sv
// rtl/systolic_deskew.sv - realigns the skewed column results of the array into one output row
module systolic_deskew
    import systolic_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_data_21,
    input  logic              i_valid_21,
    input  logic [DATA_W-1:0] i_data_22,
    input  logic              i_valid_22,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data_0,
    output logic [DATA_W-1:0] o_data_1
);

    logic [DATA_W-1:0] r_data_21;

    // Column 1 finishes one cycle ahead of column 2, so hold it until column 2 lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data_21 <= '0;
        end else if (i_valid_21) begin
            r_data_21 <= i_data_21;
        end
    end

    assign o_valid  = i_en & i_valid_22;
    assign o_data_0 = o_valid ? r_data_21 : '0;
    assign o_data_1 = o_valid ? i_data_22 : '0;

endmodule

// File: rtl/systolic_ctrl.sv
// rtl/systolic_ctrl.sv - job sequencer for a 2x2 weight-stationary systolic array
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter  int DATA_W   = DATA_W_DEF,
    parameter  int MAX_ROWS = MAX_ROWS_DEF,
    localparam int CNT_W    = $clog2(MAX_ROWS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_rows,
    input  logic [DATA_W-1:0] w11,
    input  logic [DATA_W-1:0] w12,
    input  logic [DATA_W-1:0] w21,
    input  logic [DATA_W-1:0] w22,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data_0,
    input  logic [DATA_W-1:0] in_data_1,
    output logic              sys_start,
    output logic              sys_switch_in,
    output logic              sys_accept_w_in,
    output logic [DATA_W-1:0] sys_data_in_11,
    output logic [DATA_W-1:0] sys_data_in_12,
    output logic [DATA_W-1:0] sys_weight_in_11,
    output logic [DATA_W-1:0] sys_weight_in_12,
    input  logic [DATA_W-1:0] sys_data_out_21,
    input  logic [DATA_W-1:0] sys_data_out_22,
    input  logic              sys_valid_out_21,
    input  logic              sys_valid_out_22,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data_0,
    output logic [DATA_W-1:0] out_data_1,
    output logic              busy,
    output logic              done
);

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ROWS);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_num_rows;
    logic [CNT_W-1:0]  r_rows_sent;
    logic [CNT_W-1:0]  r_rows_recv;
    logic [DATA_W-1:0] r_w11, r_w12, r_w21, r_w22;
    logic [DATA_W-1:0] r_skew;

    logic [CNT_W-1:0]  w_rows_sat;
    logic [CNT_W-1:0]  w_sent_inc;
    logic [CNT_W-1:0]  w_recv_nxt;
    logic              w_can_take;
    logic              w_xfer;
    logic              w_collect;

    assign w_rows_sat = (num_rows > MAX_CNT) ? MAX_CNT : num_rows;
    assign w_sent_inc = r_rows_sent + ONE;
    assign w_recv_nxt = out_valid ? (r_rows_recv + ONE) : r_rows_recv;
    assign w_can_take = (r_state == S_STREAM) && (r_rows_sent < r_num_rows);
    assign w_xfer     = w_can_take & in_valid;
    assign w_collect  = (r_state == S_STREAM) || (r_state == S_DRAIN);

    assign in_ready       = w_can_take;
    assign sys_start      = w_xfer;
    assign sys_data_in_11 = w_xfer ? in_data_0 : '0;
    assign sys_data_in_12 = r_skew;
    assign busy           = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_num_rows  <= '0;
            r_rows_sent <= '0;
            r_rows_recv <= '0;
            r_w11       <= '0;
            r_w12       <= '0;
            r_w21       <= '0;
            r_w22       <= '0;
            r_skew      <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Column 2 of the array sees its element one cycle after column 1.
            r_skew  <= w_xfer ? in_data_1 : '0;
            if (r_state == S_IDLE && start) begin
                r_num_rows  <= w_rows_sat;
                r_w11       <= w11;
                r_w12       <= w12;
                r_w21       <= w21;
                r_w22       <= w22;
                r_rows_sent <= '0;
                r_rows_recv <= '0;
            end else begin
                if (w_xfer) begin
                    r_rows_sent <= w_sent_inc;
                end
                r_rows_recv <= w_recv_nxt;
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        sys_switch_in    = 1'b0;
        sys_accept_w_in  = 1'b0;
        sys_weight_in_11 = '0;
        sys_weight_in_12 = '0;
        done             = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_LOAD_W1;
            end
            // Bottom row goes in first so it is shifted down by the second load.
            S_LOAD_W1: begin
                sys_accept_w_in  = 1'b1;
                sys_weight_in_11 = r_w21;
                sys_weight_in_12 = r_w22;
                w_state_nxt      = S_LOAD_W0;
            end
            S_LOAD_W0: begin
                sys_accept_w_in  = 1'b1;
                sys_weight_in_11 = r_w11;
                sys_weight_in_12 = r_w12;
                w_state_nxt      = S_SWITCH;
            end
            S_SWITCH: begin
                sys_switch_in = 1'b1;
                w_state_nxt   = (r_num_rows == '0) ? S_DONE : S_STREAM;
            end
            S_STREAM: begin
                if (w_xfer && (w_sent_inc == r_num_rows)) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_recv_nxt == r_num_rows) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    systolic_deskew #(
        .DATA_W (DATA_W)
    ) u_deskew (
        .clk        (clk),
        .rst        (rst),
        .i_en       (w_collect),
        .i_data_21  (sys_data_out_21),
        .i_valid_21 (sys_valid_out_21),
        .i_data_22  (sys_data_out_22),
        .i_valid_22 (sys_valid_out_22),
        .o_valid    (out_valid),
        .o_data_0   (out_data_0),
        .o_data_1   (out_data_1)
    );

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb/tb_systolic_ctrl.sv - scoreboard bench for systolic_ctrl with a behavioural 2x2 array model
module tb_systolic_ctrl;

    localparam int DW = 16;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] num_rows;
    logic [DW-1:0] w11, w12, w21, w22;
    logic          in_valid, in_ready;
    logic [DW-1:0] in_data_0, in_data_1;
    logic          sys_start, sys_switch_in, sys_accept_w_in;
    logic [DW-1:0] sys_data_in_11, sys_data_in_12, sys_weight_in_11, sys_weight_in_12;
    logic [DW-1:0] sys_data_out_21, sys_data_out_22;
    logic          sys_valid_out_21, sys_valid_out_22;
    logic          out_valid;
    logic [DW-1:0] out_data_0, out_data_1;
    logic          busy, done;

    always #5 clk = ~clk;

    systolic_ctrl #(.DATA_W(DW), .MAX_ROWS(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .num_rows         (num_rows),
        .w11              (w11),
        .w12              (w12),
        .w21              (w21),
        .w22              (w22),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data_0        (in_data_0),
        .in_data_1        (in_data_1),
        .sys_start        (sys_start),
        .sys_switch_in    (sys_switch_in),
        .sys_accept_w_in  (sys_accept_w_in),
        .sys_data_in_11   (sys_data_in_11),
        .sys_data_in_12   (sys_data_in_12),
        .sys_weight_in_11 (sys_weight_in_11),
        .sys_weight_in_12 (sys_weight_in_12),
        .sys_data_out_21  (sys_data_out_21),
        .sys_data_out_22  (sys_data_out_22),
        .sys_valid_out_21 (sys_valid_out_21),
        .sys_valid_out_22 (sys_valid_out_22),
        .out_valid        (out_valid),
        .out_data_0       (out_data_0),
        .out_data_1       (out_data_1),
        .busy             (busy),
        .done             (done)
    );

    int tests = 0;
    int fails = 0;
    int n_start, n_outv, n_done, n_busy, n_ready, n_switch;
    logic [31:0] sb[$];
    logic [31:0] wq[$];
    logic        xfer_seen;
    logic [DW-1:0] jw11, jw12, jw21, jw22;
    logic [DW-1:0] sw11, sw12, sw21, sw22, aw11, aw12, aw21, aw22;
    logic          s1_v, s2_v, s3_v;
    logic [DW-1:0] s1_x0, s1_x1, s2_y0, s2_y1, s3_y1;
    logic [31:0]   last_out;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rowres(input logic [DW-1:0] x0, x1, a11, a12, a21, a22);
        logic [DW-1:0] y0, y1;
        y0 = x0 * a11 + x1 * a21;
        y1 = x0 * a12 + x1 * a22;
        return {y0, y1};
    endfunction

    task automatic stub_clear();
        s1_v = 1'b0; s2_v = 1'b0; s3_v = 1'b0;
        s1_x0 = '0; s1_x1 = '0; s2_y0 = '0; s2_y1 = '0; s3_y1 = '0;
        sb.delete();
    endtask

    task automatic sample();
        logic xf;
        logic [31:0] exp;
        xf = in_valid && in_ready;
        if (busy) n_busy++;
        if (in_ready) n_ready++;
        if (sys_switch_in) n_switch++;
        chk("sys_start", {31'd0, sys_start}, {31'd0, xf});
        chk("data_in_11", {16'd0, sys_data_in_11}, xf ? {16'd0, in_data_0} : 32'd0);
        chk("skew_12", {16'd0, sys_data_in_12}, s1_v ? {16'd0, s1_x1} : 32'd0);
        if (sys_start) n_start++;
        if (xf) begin
            xfer_seen = 1'b1;
            sb.push_back(rowres(in_data_0, in_data_1, jw11, jw12, jw21, jw22));
        end
        if (sys_accept_w_in) begin
            wq.push_back({sys_weight_in_11, sys_weight_in_12});
            sw21 = sw11; sw22 = sw12;
            sw11 = sys_weight_in_11; sw12 = sys_weight_in_12;
        end else begin
            chk("w_idle", {sys_weight_in_11, sys_weight_in_12}, 32'd0);
        end
        if (sys_switch_in) begin
            aw11 = sw11; aw12 = sw12; aw21 = sw21; aw22 = sw22;
        end
        if (out_valid) begin
            n_outv++;
            last_out = {out_data_0, out_data_1};
            if (sb.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                exp = sb.pop_front();
                chk("out_row", {out_data_0, out_data_1}, exp);
            end
        end
        if (done) begin
            n_done++;
            chk("done_sb", sb.size(), 32'd0);
            chk("done_busy", {31'd0, busy}, 32'd1);
        end
        s3_v = s2_v; s3_y1 = s2_y1;
        s2_v = s1_v;
        if (s1_v) {s2_y0, s2_y1} = rowres(s1_x0, sys_data_in_12, aw11, aw12, aw21, aw22);
        s1_v = sys_start; s1_x0 = sys_data_in_11; s1_x1 = in_data_1;
    endtask

    task automatic cyc();
        sys_valid_out_21 = s2_v;
        sys_data_out_21  = s2_v ? s2_y0 : 16'hDEAD;
        sys_valid_out_22 = s3_v;
        sys_data_out_22  = s3_v ? s3_y1 : 16'hBEEF;
        #1;
        sample();
        @(negedge clk);
    endtask

    task automatic start_job(input int n, input logic [DW-1:0] a11, a12, a21, a22);
        jw11 = a11; jw12 = a12; jw21 = a21; jw22 = a22;
        wq.delete();
        n_start = 0; n_outv = 0; n_done = 0; n_busy = 0; n_ready = 0; n_switch = 0;
        num_rows = CW'(n);
        w11 = a11; w12 = a12; w21 = a21; w22 = a22;
        start = 1'b1;
        cyc();
        start = 1'b0;
        num_rows = CW'($urandom);
        w11 = DW'($urandom); w12 = DW'($urandom); w21 = DW'($urandom); w22 = DW'($urandom);
    endtask

    task automatic send_row(input logic [DW-1:0] x0, x1, input bit glitch);
        in_valid = 1'b1; in_data_0 = x0; in_data_1 = x1;
        xfer_seen = 1'b0;
        for (int k = 0; k < 20 && !xfer_seen; k++) begin
            if (glitch && k == 0) begin
                start = 1'b1; num_rows = CW'(1);
                w11 = 16'd99; w12 = 16'd98; w21 = 16'd97; w22 = 16'd96;
            end
            cyc();
            start = 1'b0;
        end
        if (!xfer_seen) chk("xfer_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic feed(input int n, input bit bubble, input int glitch_row);
        for (int i = 0; i < n; i++) begin
            if (bubble && i > 0) begin
                in_valid = 1'b0; in_data_0 = DW'($urandom); in_data_1 = DW'($urandom);
                cyc();
            end
            send_row(DW'($urandom_range(0, 255)), DW'($urandom_range(0, 255)), i == glitch_row);
        end
    endtask

    task automatic wait_done();
        for (int k = 0; k < 80 && n_done == 0; k++) cyc();
        cyc();
        chk("done_once", n_done, 32'd1);
        chk("idle_after", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_rows = '0;
        w11 = '0; w12 = '0; w21 = '0; w22 = '0;
        in_valid = 1'b0; in_data_0 = '0; in_data_1 = '0;
        sys_valid_out_21 = 1'b0; sys_valid_out_22 = 1'b1;
        sys_data_out_21 = 16'h1111; sys_data_out_22 = 16'h2222;
        sw11 = '0; sw12 = '0; sw21 = '0; sw22 = '0;
        aw11 = '0; aw12 = '0; aw21 = '0; aw22 = '0;
        last_out = '0;
        stub_clear();
        #1 rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_ctrl", {25'd0, busy, in_ready, done, out_valid, sys_start, sys_switch_in, sys_accept_w_in}, 32'd0);
        chk("rst_data", {sys_data_in_11, sys_data_in_12}, 32'd0);
        chk("rst_wts", {sys_weight_in_11, sys_weight_in_12}, 32'd0);
        chk("rst_out", {out_data_0, out_data_1}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        sys_valid_out_22 = 1'b0;
        @(negedge clk);

        start_job(1, 16'd1, 16'd2, 16'd3, 16'd4);
        send_row(16'd5, 16'd6, 1'b0);
        wait_done();
        chk("wq_size", wq.size(), 32'd2);
        chk("wq_first", (wq.size() > 0) ? wq[0] : 32'hFFFFFFFF, 32'h00030004);
        chk("wq_second", (wq.size() > 1) ? wq[1] : 32'hFFFFFFFF, 32'h00010002);
        chk("switch_cnt", n_switch, 32'd1);
        chk("one_row_out", last_out, {16'd23, 16'd34});

        start_job(3, DW'($urandom_range(0, 15)), DW'($urandom_range(0, 15)),
                  DW'($urandom_range(0, 15)), DW'($urandom_range(0, 15)));
        feed(3, 1'b1, -1);
        wait_done();
        chk("bubble_starts", n_start, 32'd3);
        chk("bubble_outs", n_outv, 32'd3);

        start_job(0, 16'd1, 16'd1, 16'd1, 16'd1);
        wait_done();
        chk("zero_busy", n_busy, 32'd4);
        chk("zero_ready", n_ready, 32'd0);
        chk("zero_starts", n_start, 32'd0);

        start_job(4, 16'd5, 16'd6, 16'd7, 16'd8);
        feed(4, 1'b0, 2);
        wait_done();
        chk("glitch_starts", n_start, 32'd4);
        chk("glitch_outs", n_outv, 32'd4);

        start_job(4, 16'd2, 16'd3, 16'd4, 16'd5);
        feed(2, 1'b0, -1);
        in_valid = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("abort_ctrl", {26'd0, busy, in_ready, done, out_valid, sys_start, sys_switch_in}, 32'd0);
        chk("abort_data", {sys_data_in_11, sys_data_in_12}, 32'd0);
        in_valid = 1'b0;
        stub_clear();
        @(negedge clk);
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        chk("post_rst_idle", {31'd0, busy}, 32'd0);
        chk("abort_no_done", n_done, 32'd0);
        start_job(2, 16'd3, 16'd1, 16'd4, 16'd1);
        feed(2, 1'b0, -1);
        wait_done();
        chk("rejob_outs", n_outv, 32'd2);

        start_job(1, 16'd7, 16'd9, 16'd0, 16'd0);
        send_row(16'd1, 16'd0, 1'b0);
        wait_done();
        chk("deskew_cnt", n_outv, 32'd1);
        chk("deskew_val", last_out, {16'd7, 16'd9});

        start_job(20, DW'($urandom_range(0, 15)), DW'($urandom_range(0, 15)),
                  DW'($urandom_range(0, 15)), DW'($urandom_range(0, 15)));
        feed(16, 1'b0, -1);
        wait_done();
        chk("sat_starts", n_start, 32'd16);
        chk("sat_ready", n_ready, 32'd16);
        chk("sat_outs", n_outv, 32'd16);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, width of every data, weight and result word.
REQ-002 Parameter MAX_ROWS, default 16, maximum input rows per job; CNT_W = $clog2(MAX_ROWS+1).
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle job request; sampled only in IDLE.
REQ-006 num_rows  in  CNT_W  rows in the job; sampled with start.
REQ-007 w11, w12, w21, w22  in  DATA_W each  2x2 weight matrix; sampled with start.
REQ-008 in_valid / in_ready  in / out  1 / 1  input row handshake; transfer when both are high.
REQ-009 in_data_0, in_data_1  in  DATA_W each  row elements for array columns 1 and 2.
REQ-010 sys_start, sys_switch_in, sys_accept_w_in  out  1 each  array control.
REQ-011 sys_data_in_11, sys_data_in_12, sys_weight_in_11, sys_weight_in_12  out  DATA_W each  array operands.
REQ-012 sys_data_out_21, sys_data_out_22  in  DATA_W each; sys_valid_out_21, sys_valid_out_22  in  1 each  array results.
REQ-013 out_valid  out  1; out_data_0, out_data_1  out  DATA_W each  deskewed result row; no backpressure.
REQ-014 busy  out  1  high outside IDLE; done  out  1  one-cycle pulse at job end.

Function
REQ-015 FSM states: IDLE, LOAD_W1, LOAD_W0, SWITCH, STREAM, DRAIN, DONE.
REQ-016 IDLE -> LOAD_W1 on start; the controller latches num_rows and weights on the same edge.
REQ-017 LOAD_W1 (1 cycle): sys_accept_w_in=1, sys_weight_in_11=w21, sys_weight_in_12=w22.
REQ-018 LOAD_W0 (1 cycle): sys_accept_w_in=1, sys_weight_in_11=w11, sys_weight_in_12=w12.
REQ-019 SWITCH (1 cycle): sys_switch_in=1; next state is STREAM, or DONE if latched num_rows==0.
REQ-020 STREAM: in_ready=1 while rows_sent<num_rows; each transfer drives sys_start=1 and sys_data_in_11=in_data_0 in that cycle, and increments rows_sent.
REQ-021 sys_data_in_12 shall present in_data_1 one cycle after its transfer (skew register); the value is 0 when no transfer occurred in the prior cycle.
REQ-022 Input bubbles (in_valid=0) in STREAM shall produce sys_start=0 and sys_data_in_11=0.
REQ-023 STREAM -> DRAIN on the transfer where rows_sent reaches num_rows.
REQ-024 Result deskew: on sys_valid_out_21, the controller registers sys_data_out_21; on sys_valid_out_22, it drives out_valid=1 with out_data_0=registered value and out_data_1=sys_data_out_22 in the same cycle.
REQ-025 rows_recv increments per out_valid; DRAIN -> DONE when rows_recv==num_rows, including a result arriving while still in STREAM.
REQ-026 DONE (1 cycle): done=1, then IDLE; in DONE, out_valid has already fired num_rows times.
REQ-027 start outside IDLE shall be ignored; num_rows>MAX_ROWS shall be saturated to MAX_ROWS.
REQ-028 All sys_* control outputs and operands are 0 in states where they are not driven above.

Reset
REQ-029 On assertion of rst: state=IDLE; counters, latched weights, skew and deskew registers=0; all outputs 0, including in_ready, busy, done and out_valid.
REQ-030 rst asserted mid-job aborts it; no done pulse is produced, and the first post-reset cycle is IDLE.

Structure
REQ-031 A shared package systolic_pkg shall hold the state enum type, DATA_W default, and the MAX_ROWS default.
REQ-032 One sub-module, systolic_deskew, shall implement REQ-024; everything else resides in systolic_ctrl.

Verification
REQ-033 W=[[1,2],[3,4]], num_rows=1, X row (5,6) -> sequence LOAD_W1 weights (3,4), then (1,2), then a switch pulse; sys_data_in_12=6 exactly one cycle after sys_data_in_11=5; one done pulse.
REQ-034 num_rows=3 with in_valid bubbles between rows -> exactly 3 sys_start pulses, 3 out_valid, rows in order, done after the third.
REQ-035 num_rows=0 -> load, switch, DONE; no in_ready, no sys_start, done after 4 busy cycles.
REQ-036 start pulsed during STREAM -> ignored; latched num_rows and weights unchanged.
REQ-037 rst low during STREAM of a 4-row job -> all outputs 0 asynchronously, no done; a new 2-row job then completes normally.
REQ-038 Deskew check: stub sys_valid_out_22 one cycle after sys_valid_out_21 with outputs 7 and 9 -> out_valid once with (7,9).
